// File: rtl/frame_pingpong_buffer.sv
// frame_pingpong_buffer
//   Double-banked frame buffer between a capture stream and a display stream.
//   The writer fills one bank with a frame-aligned pixel stream. The reader
//   streams the last completed frame from the other bank. Banks swap only at a
//   reader frame boundary, so a frame is never torn. With no new frame the
//   reader repeats the current one. A completed frame that is overtaken by the
//   next input frame before display is dropped.
//
// Ports
//   clk       single clock for both sides
//   rst       synchronous, active-high reset
//   s_valid   input pixel valid (always accepted)
//   s_sof     first pixel of an input frame (qualified by s_valid)
//   s_data    input pixel
//   m_valid   output pixel valid
//   m_ready   downstream accept
//   m_data    output pixel
//   m_sof     first pixel of the output frame
//   m_eol     last pixel of each output line
//   m_eof     last pixel of the output frame
//   drop_cnt  frames overwritten before display (saturating)
//   err_cnt   frames restarted by a premature s_sof (saturating)
module frame_pingpong_buffer #(
    parameter int DATA_W = 12,
    parameter int H_RES  = 320,
    parameter int V_RES  = 240
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic              s_sof,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic [7:0]        drop_cnt,
    output logic [7:0]        err_cnt
);

    localparam int DEPTH     = H_RES * V_RES;
    localparam int ADDR_W    = $clog2(DEPTH);
    localparam int COL_W     = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int BEAT_W    = DATA_W + 3;
    // Bank select is the top address bit, so each bank spans 2**ADDR_W words;
    // this is exactly 2*DEPTH when DEPTH is a power of two.
    localparam int MEM_WORDS = 2 * (1 << ADDR_W);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(H_RES - 1);

    typedef enum logic {W_IDLE, W_WRITE} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_SWAP, R_READ} r_state_t;

    (* ram_style = "block" *) logic [DATA_W-1:0] r_mem [0:MEM_WORDS-1];

    w_state_t          r_wr_state, w_wr_state_nxt;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt, w_waddr;
    logic              r_wr_bank, r_rd_bank, w_wr_bank_eff;
    logic              r_pending, r_have_frame;
    logic [7:0]        r_drop_cnt, r_err_cnt;
    logic              w_we, w_frame_done, w_err, w_drop, w_swap, w_sof_in;

    r_state_t          r_rd_state, w_rd_state_nxt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [COL_W-1:0]  r_rd_col;
    logic              w_re, w_rd_start;

    logic [DATA_W-1:0] r_rdata_p1;
    logic [2:0]        r_flags_p1;
    logic              r_vld_p1;
    logic [BEAT_W-1:0] w_pipe_beat;

    logic [BEAT_W-1:0] r_q0, r_q1, w_head;
    logic [1:0]        r_q_cnt;
    logic [2:0]        w_items;
    logic              w_out_vld, w_xfer, w_pop, w_push, w_drained, w_room;

    // ---------------------------------------------------------------- writer
    assign w_sof_in = s_valid && s_sof;

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_addr_nxt  = r_wr_addr;
        w_waddr        = r_wr_addr;
        w_we           = 1'b0;
        w_frame_done   = 1'b0;
        w_err          = 1'b0;
        unique case (r_wr_state)
            W_IDLE: begin
                if (w_sof_in) begin
                    w_we           = 1'b1;
                    w_waddr        = '0;
                    w_wr_addr_nxt  = ADDR_W'(1);
                    w_wr_state_nxt = W_WRITE;
                end
            end
            W_WRITE: begin
                if (s_valid) begin
                    w_we = 1'b1;
                    if (s_sof) begin
                        // Restart the frame in place; the partial frame is lost.
                        w_waddr       = '0;
                        w_wr_addr_nxt = ADDR_W'(1);
                        w_err         = 1'b1;
                    end else if (r_wr_addr == LAST_ADDR) begin
                        w_frame_done   = 1'b1;
                        w_wr_addr_nxt  = '0;
                        w_wr_state_nxt = W_IDLE;
                    end else begin
                        w_wr_addr_nxt = r_wr_addr + ADDR_W'(1);
                    end
                end
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    // A swap in the same cycle as an s_sof redirects that pixel to the new
    // write bank and consumes the pending frame, so no drop is counted.
    assign w_swap        = (r_rd_state == R_SWAP) && w_drained && r_pending;
    assign w_wr_bank_eff = w_swap ? ~r_wr_bank : r_wr_bank;
    assign w_drop        = w_sof_in && r_pending && !w_swap;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[{w_wr_bank_eff, w_waddr}] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state   <= W_IDLE;
            r_wr_addr    <= '0;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b1;
            r_pending    <= 1'b0;
            r_have_frame <= 1'b0;
            r_drop_cnt   <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            if (w_swap) begin
                r_rd_bank <= r_wr_bank;
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_swap || w_drop) begin
                r_pending <= 1'b0;
            end else if (w_frame_done) begin
                r_pending <= 1'b1;
            end
            if (w_frame_done) begin
                r_have_frame <= 1'b1;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    // ---------------------------------------------------------------- reader
    assign w_items   = {1'b0, r_q_cnt} + {2'b00, r_vld_p1};
    assign w_out_vld = (r_q_cnt != 2'd0) || r_vld_p1;
    assign w_xfer    = w_out_vld && m_ready;
    // Everything already read leaves the output this cycle.
    assign w_drained = (w_items == 3'd0) || ((w_items == 3'd1) && w_xfer);
    // A new read is safe if at most one item remains queued after this cycle,
    // leaving a slot for the read currently in flight.
    assign w_room    = ((w_items - {2'b00, w_xfer}) <= 3'd1);

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_re           = 1'b0;
        w_rd_start     = 1'b0;
        unique case (r_rd_state)
            R_IDLE: begin
                if (r_have_frame || w_frame_done) begin
                    w_rd_state_nxt = R_SWAP;
                end
            end
            R_SWAP: begin
                // Held until the previous frame's last beat is leaving, so the
                // bank decision is made exactly at the frame boundary.
                if (w_drained) begin
                    w_rd_state_nxt = R_READ;
                    w_rd_start     = 1'b1;
                end
            end
            R_READ: begin
                if (w_room) begin
                    w_re = 1'b1;
                    if (r_rd_addr == LAST_ADDR) begin
                        w_rd_state_nxt = R_SWAP;
                    end
                end
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_rd_addr  <= '0;
            r_rd_col   <= '0;
            r_vld_p1   <= 1'b0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_vld_p1   <= w_re;
            if (w_rd_start) begin
                r_rd_addr <= '0;
                r_rd_col  <= '0;
            end else if (w_re) begin
                r_rd_addr <= (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + ADDR_W'(1);
                r_rd_col  <= (r_rd_col == LAST_COL) ? '0 : r_rd_col + COL_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------- p1: registered read
    always_ff @(posedge clk) begin
        if (w_re) begin
            r_rdata_p1 <= r_mem[{r_rd_bank, r_rd_addr}];
            r_flags_p1 <= {(r_rd_addr == '0), (r_rd_col == LAST_COL), (r_rd_addr == LAST_ADDR)};
        end
    end

    assign w_pipe_beat = {r_rdata_p1, r_flags_p1};

    // ---------------------------------------------------------------- output skid buffer
    assign w_pop  = w_xfer && (r_q_cnt != 2'd0);
    assign w_push = r_vld_p1 && !(w_xfer && (r_q_cnt == 2'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_cnt <= 2'd0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_q_cnt <= r_q_cnt + 2'd1;
                2'b01:   r_q_cnt <= r_q_cnt - 2'd1;
                default: r_q_cnt <= r_q_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        unique case ({w_push, w_pop})
            2'b01: r_q0 <= r_q1;
            2'b10: begin
                if (r_q_cnt == 2'd0) r_q0 <= w_pipe_beat;
                else                 r_q1 <= w_pipe_beat;
            end
            2'b11: begin
                if (r_q_cnt == 2'd1) begin
                    r_q0 <= w_pipe_beat;
                end else begin
                    r_q0 <= r_q1;
                    r_q1 <= w_pipe_beat;
                end
            end
            default: ;
        endcase
    end

    // The head bypasses the queue when it is empty so a fresh read reaches the
    // output one cycle after it is issued; idle outputs are forced to zero.
    assign w_head   = (r_q_cnt != 2'd0) ? r_q0 : w_pipe_beat;
    assign m_valid  = w_out_vld;
    assign m_data   = w_out_vld ? w_head[BEAT_W-1:3] : '0;
    assign m_sof    = w_out_vld && w_head[2];
    assign m_eol    = w_out_vld && w_head[1];
    assign m_eof    = w_out_vld && w_head[0];
    assign drop_cnt = r_drop_cnt;
    assign err_cnt  = r_err_cnt;

endmodule
